// File: rtl/apb_acq_sequencer_if.sv
// APB bus between the acquisition sequencer (initiator) and the
// data-acquisition peripheral (completer).
interface apb_acq_sequencer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_acq_sequencer.sv
// Hardware APB initiator that runs one complete measurement on the
// acquisition peripheral: write CPU_CMD, poll STATUS, read RESULT,
// clear status, write CPU_CMD back to zero.
//
// state       | meaning
// ------------+----------------------------------------------------
// S_IDLE      | waiting for start; bus idle
// S_WR_CMD    | writing cmd_word to CPU_CMD (0x00)
// S_RD_STAT   | reading STATUS (0x04), bit0 = measurement done
// S_POLL_WAIT | bus idle for POLL_GAP cycles before the next poll
// S_RD_RES    | reading RESULT (0x08)
// S_WR_CLR    | writing 0x1 to CLEAR (0x0C)
// S_WR_ZERO   | writing 0 to CPU_CMD; always the last transfer
//
// In a transfer state, PSEL=0 means the bus is in its mandatory idle gap
// and the next edge launches SETUP for that state's transfer.
module apb_acq_sequencer #(
  parameter int MAX_POLLS = 1024,
  parameter int POLL_GAP  = 4,
  parameter int PCNT_W    = 11
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       start,
  input  logic [31:0]                cmd_word,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                result_value,
  output logic [2:0]                 result_err,
  output logic                       err_slverr,
  output logic                       err_timeout,
  apb_acq_sequencer_if.master        apb
);

  localparam logic [7:0] ADDR_CMD  = 8'h00;
  localparam logic [7:0] ADDR_STAT = 8'h04;
  localparam logic [7:0] ADDR_RES  = 8'h08;
  localparam logic [7:0] ADDR_CLR  = 8'h0C;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(POLL_GAP - 1);
  localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(MAX_POLLS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_CMD    = 3'd1,
    S_RD_STAT   = 3'd2,
    S_POLL_WAIT = 3'd3,
    S_RD_RES    = 3'd4,
    S_WR_CLR    = 3'd5,
    S_WR_ZERO   = 3'd6
  } state_t;

  state_t            state;
  logic [31:0]       cmd_q;
  logic [PCNT_W-1:0] poll_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  // PRDATA bits between the done flag and the result error field carry nothing here
  logic unused_prdata;
  assign unused_prdata = ^apb.PRDATA[12:1];

  // Transfer attributes for a state, packed as {PWRITE, PADDR, PWDATA, PSTRB}
  function automatic logic [44:0] xfer_fields(state_t s, logic [31:0] cmd);
    case (s)
      S_WR_CMD:  return {1'b1, ADDR_CMD,  cmd,   4'b1111};
      S_RD_STAT: return {1'b0, ADDR_STAT, 32'h0, 4'b0000};
      S_RD_RES:  return {1'b0, ADDR_RES,  32'h0, 4'b0000};
      S_WR_CLR:  return {1'b1, ADDR_CLR,  32'h1, 4'b0001};
      default:   return {1'b1, ADDR_CMD,  32'h0, 4'b1111};
    endcase
  endfunction

  // Sequencer FSM: drives the APB master signals and the local status outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state        <= S_IDLE;
      cmd_q        <= '0;
      poll_cnt     <= '0;
      gap_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_value <= '0;
      result_err   <= '0;
      err_slverr   <= 1'b0;
      err_timeout  <= 1'b0;
      apb.PSEL     <= 1'b0;
      apb.PENABLE  <= 1'b0;
      apb.PWRITE   <= 1'b0;
      apb.PADDR    <= '0;
      apb.PWDATA   <= '0;
      apb.PSTRB    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            cmd_q        <= cmd_word;
            poll_cnt     <= '0;
            result_value <= '0;
            result_err   <= '0;
            err_slverr   <= 1'b0;
            err_timeout  <= 1'b0;
            state        <= S_WR_CMD;
            apb.PSEL     <= 1'b1;
            {apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB} <= xfer_fields(S_WR_CMD, cmd_word);
          end
        end

        S_POLL_WAIT: begin
          if (gap_cnt == '0) begin
            state    <= S_RD_STAT;
            apb.PSEL <= 1'b1;
            {apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB} <= xfer_fields(S_RD_STAT, cmd_q);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          if (!apb.PSEL) begin
            apb.PSEL <= 1'b1;
            {apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB} <= xfer_fields(state, cmd_q);
          end else if (!apb.PENABLE) begin
            apb.PENABLE <= 1'b1;
          end else if (apb.PREADY) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            if (state == S_RD_STAT) poll_cnt <= poll_cnt + 1'b1;
            if (apb.PSLVERR) begin
              err_slverr <= 1'b1;
              if (state == S_WR_ZERO) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                state <= S_WR_ZERO;
              end
            end else begin
              case (state)
                S_WR_CMD: state <= S_RD_STAT;
                S_RD_STAT: begin
                  if (apb.PRDATA[0]) begin
                    state <= S_RD_RES;
                  end else if (poll_cnt == POLL_LAST) begin
                    err_timeout <= 1'b1;
                    state       <= S_WR_ZERO;
                  end else begin
                    gap_cnt <= GAP_LOAD;
                    state   <= S_POLL_WAIT;
                  end
                end
                S_RD_RES: begin
                  result_value <= apb.PRDATA[31:16];
                  result_err   <= apb.PRDATA[15:13];
                  state        <= S_WR_CLR;
                end
                S_WR_CLR: state <= S_WR_ZERO;
                default: begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
